// File: rtl/seg7_pkg.sv
// Shared constants for the 8-digit seven-segment scan driver.
// Segment codes are active-low {g,f,e,d,c,b,a}.
package seg7_pkg;

    localparam int NUM_DIGITS = 8;

    typedef enum logic [1:0] {
        SRC_LED = 2'd0,
        SRC_ALL = 2'd1,
        SRC_BR  = 2'd2,
        SRC_JMP = 2'd3
    } src_sel_e;

    // Element n holds the pattern for hex digit n (listed F down to 0).
    localparam logic [15:0][6:0] HEX_SEG = {
        7'h0E, 7'h06, 7'h21, 7'h46, 7'h03, 7'h08, 7'h10, 7'h00,
        7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 7'h40
    };

    localparam logic [6:0] SEG_BLANK = 7'h7F;

endpackage

// File: rtl/hex_to_seg7.sv
// Combinational hex nibble to active-low segment decoder with blank override.
module hex_to_seg7
    import seg7_pkg::*;
(
    input  logic [3:0] nibble,
    input  logic       blank,
    output logic [6:0] seg
);

    assign seg = blank ? SEG_BLANK : HEX_SEG[nibble];

endmodule

// File: rtl/seg7_scan_display.sv
// Time-multiplexed 8-digit hex display; source word snapshotted once per frame.
// Outputs are combinational decodes of registered state, no output register.
module seg7_scan_display
    import seg7_pkg::*;
#(
    parameter int SCAN_DIV = 100000,
    parameter bit BLANK_LZ = 1'b0
) (
    input  logic        clk,
    input  logic        clr,
    input  logic [1:0]  sel,
    input  logic [31:0] leddata,
    input  logic [31:0] count_all,
    input  logic [31:0] count_branch,
    input  logic [31:0] count_jmp,
    output logic [7:0]  an,
    output logic [6:0]  seg,
    output logic        dp,
    output logic        frame_start
);

    localparam int CNT_W   = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int DIGIT_W = $clog2(NUM_DIGITS);
    localparam logic [CNT_W-1:0]   DIV_LAST   = CNT_W'(SCAN_DIV - 1);
    localparam logic [DIGIT_W-1:0] DIGIT_LAST = DIGIT_W'(NUM_DIGITS - 1);

    logic [CNT_W-1:0]   div_q, div_d;
    logic [DIGIT_W-1:0] digit_q, digit_d;
    logic [31:0]        snap_q, snap_d;
    logic               frame_start_q, frame_start_d;
    logic [31:0]        src_word;

    always_comb begin
        src_word = leddata;
        case (src_sel_e'(sel))
            SRC_LED: src_word = leddata;
            SRC_ALL: src_word = count_all;
            SRC_BR:  src_word = count_branch;
            SRC_JMP: src_word = count_jmp;
            default: src_word = leddata;
        endcase
    end

    always_comb begin
        div_d         = CNT_W'(div_q + 1'b1);
        digit_d       = digit_q;
        snap_d        = snap_q;
        frame_start_d = 1'b0;
        if (div_q == DIV_LAST) begin
            div_d   = '0;
            digit_d = DIGIT_W'(digit_q + 1'b1);
            // Snapshot only at the frame boundary so a frame never tears.
            if (digit_q == DIGIT_LAST) begin
                snap_d        = src_word;
                frame_start_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            div_q         <= '0;
            digit_q       <= '0;
            snap_q        <= '0;
            frame_start_q <= 1'b0;
        end else begin
            div_q         <= div_d;
            digit_q       <= digit_d;
            snap_q        <= snap_d;
            frame_start_q <= frame_start_d;
        end
    end

    logic [4:0]  nib_lsb;
    logic [3:0]  nibble;
    logic [31:0] upper_bits;
    logic        blank;

    assign nib_lsb    = {digit_q, 2'b00};
    assign nibble     = snap_q[nib_lsb +: 4];
    assign upper_bits = snap_q >> nib_lsb;
    assign blank      = BLANK_LZ && (digit_q != '0) && (upper_bits == '0);

    hex_to_seg7 u_hex (
        .nibble (nibble),
        .blank  (blank),
        .seg    (seg)
    );

    assign an          = ~(8'b1 << digit_q);
    // Decimal point on the rightmost digit flags counter mode, from live sel.
    assign dp          = !((digit_q == '0) && (src_sel_e'(sel) != SRC_LED));
    assign frame_start = frame_start_q;

endmodule
